// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use, branch and mult/div stall detection, operand
// forwarding select, and a saturating count of fetch-stall cycles.
module hazard_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        MdStartD,
    input  logic        MdStartE,
    input  logic        MdDivE,
    input  logic        MdReadD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MdBusy,
    output logic [31:0] StallCycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    md_state_t              r_state;
    md_state_t              w_state_nxt;
    logic [5:0]             r_cnt;
    logic [5:0]             w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_lwstall;
    logic w_branchstall;
    logic w_mdstall;
    logic w_stall;

    // Register $0 is hardwired, so a zero source never matches anything.
    function automatic logic f_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] f_fwd_e(
        input logic [4:0] src,
        input logic [4:0] wr_m,
        input logic       we_m,
        input logic [4:0] wr_w,
        input logic       we_w
    );
        if (we_m && f_match(src, wr_m))
            return 2'b10;
        else if (we_w && f_match(src, wr_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_lwstall = MemtoRegE && (f_match(RsD, WriteRegE) || f_match(RtD, WriteRegE));

        w_branchstall = BranchD &&
            ((RegWriteE && (f_match(RsD, WriteRegE) || f_match(RtD, WriteRegE))) ||
             (MemtoRegM && (f_match(RsD, WriteRegM) || f_match(RtD, WriteRegM))));

        // The final busy cycle (cnt == 0) already has the result available.
        w_mdstall = (MdReadD || MdStartD) &&
            (MdStartE || ((r_state != IDLE) && (r_cnt != 6'd0)));

        w_stall = w_lwstall || w_branchstall || w_mdstall;
    end

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;

    assign ForwardAD = RegWriteM && f_match(RsD, WriteRegM);
    assign ForwardBD = RegWriteM && f_match(RtD, WriteRegM);
    assign ForwardAE = f_fwd_e(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign ForwardBE = f_fwd_e(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (MdStartE) begin
                    w_state_nxt = MdDivE ? DIV : MULT;
                    w_cnt_nxt   = MdDivE ? DIV_LOAD : MULT_LOAD;
                end
            end
            MULT, DIV: begin
                // A new start while occupied is dropped; the count keeps running.
                if (r_cnt != 6'd0)
                    w_cnt_nxt = r_cnt - 6'd1;
                else
                    w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign MdBusy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign StallCycles = 32'(r_stall_cnt);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one default instance plus a short-parameter
// instance that exercises 1-cycle multiply and counter saturation.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic        BranchD, MdStartD, MdStartE, MdDivE, MdReadD;

    logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCycles;

    logic        s_StallF, s_StallD, s_FlushE, s_ForwardAD, s_ForwardBD, s_MdBusy;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic [31:0] s_StallCycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MdStartD(MdStartD), .MdStartE(MdStartE), .MdDivE(MdDivE), .MdReadD(MdReadD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .StallCycles(StallCycles)
    );

    hazard_unit #(.MULT_CYCLES(1), .DIV_CYCLES(2), .STALL_CNT_W(4)) dut_s (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MdStartD(MdStartD), .MdStartE(MdStartE), .MdDivE(MdDivE), .MdReadD(MdReadD),
        .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE),
        .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .MdBusy(s_MdBusy), .StallCycles(s_StallCycles)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MdStartD = 0; MdStartE = 0; MdDivE = 0; MdReadD = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++; $display("FAIL reset_stall got=%b exp=000", {StallF, StallD, FlushE});
        end
        checks++;
        if (MdBusy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", MdBusy);
        end
        checks++;
        if (StallCycles !== 32'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", StallCycles);
        end
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'b0) begin
            errors++; $display("FAIL reset_fwd got=%b exp=000000",
                               {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        MemtoRegE = 1; WriteRegE = 8; RsD = 8; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            errors++; $display("FAIL lw_rs got=%b exp=111", {StallF, StallD, FlushE});
        end
        RsD = 0; RtD = 8; #1;
        checks++;
        if (StallF !== 1'b1) begin
            errors++; $display("FAIL lw_rt got=%b exp=1", StallF);
        end
        RtD = 0; WriteRegE = 0; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++; $display("FAIL lw_reg0 got=%b exp=000", {StallF, StallD, FlushE});
        end
        MemtoRegE = 0; WriteRegE = 8; RsD = 8; #1;
        checks++;
        if (StallF !== 1'b0) begin
            errors++; $display("FAIL lw_not_load got=%b exp=0", StallF);
        end
        clear_inputs();
    endtask

    task automatic test_forward();
        do_reset();
        RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1; #1;
        checks++;
        if (ForwardAE !== 2'b10) begin
            errors++; $display("FAIL fwd_prio got=%b exp=10", ForwardAE);
        end
        RegWriteM = 0; #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_w got=%b exp=01", ForwardAE);
        end
        RegWriteW = 0; #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_none got=%b exp=00", ForwardAE);
        end
        RsE = 0; RtE = 7; WriteRegM = 7; RegWriteM = 1; #1;
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0010) begin
            errors++; $display("FAIL fwd_be got=%b exp=0010", {ForwardAE, ForwardBE});
        end
        RtE = 0; WriteRegM = 0; WriteRegW = 0; RegWriteW = 1; #1;
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            errors++; $display("FAIL fwd_reg0 got=%b exp=0000", {ForwardAE, ForwardBE});
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; RsD = 9; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            errors++; $display("FAIL br_stall got=%b exp=111", {StallF, StallD, FlushE});
        end
        step();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3; MemtoRegM = 0; #1;
        checks++;
        if ({StallF, ForwardAD, ForwardBD} !== 3'b001) begin
            errors++; $display("FAIL br_fwd got=%b exp=001", {StallF, ForwardAD, ForwardBD});
        end
        MemtoRegM = 1; #1;
        checks++;
        if (StallF !== 1'b1) begin
            errors++; $display("FAIL br_load_m got=%b exp=1", StallF);
        end
        BranchD = 0; #1;
        checks++;
        if (StallF !== 1'b0) begin
            errors++; $display("FAIL br_nobranch got=%b exp=0", StallF);
        end
        clear_inputs();
    endtask

    task automatic test_multiply();
        logic [4:0] exp_stall;
        logic [5:0] exp_busy;
        exp_stall = 5'b01111;   // cycles 0..4, bit i = cycle i
        exp_busy  = 6'b011110;  // cycles 0..5
        do_reset();
        MdStartE = 1; MdDivE = 0; MdReadD = 1; #1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                step();
                MdStartE = 0; #1;
            end
            if (c <= 4) begin
                checks++;
                if (StallF !== exp_stall[c]) begin
                    errors++; $display("FAIL mul_stall c=%0d got=%b exp=%b", c, StallF, exp_stall[c]);
                end
            end
            checks++;
            if (MdBusy !== exp_busy[c]) begin
                errors++; $display("FAIL mul_busy c=%0d got=%b exp=%b", c, MdBusy, exp_busy[c]);
            end
            // Single-cycle multiply instance: busy only in cycle 1, stall only in cycle 0.
            if (c <= 2) begin
                checks++;
                if ({s_StallF, s_MdBusy} !== {c == 0, c == 1}) begin
                    errors++; $display("FAIL mul1 c=%0d got=%b%b exp=%b%b",
                                       c, s_StallF, s_MdBusy, c == 0, c == 1);
                end
            end
        end
        checks++;
        if (StallCycles !== 32'd4) begin
            errors++; $display("FAIL mul_count got=%0d exp=4", StallCycles);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        MdStartE = 1; MdDivE = 0; #1;
        step();
        MdStartE = 0;
        step();
        MdStartE = 1; MdDivE = 1;  // ignored while MULT is running
        step();
        MdStartE = 0;
        step();
        checks++;
        if (MdBusy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy4 got=%b exp=1", MdBusy);
        end
        step();
        checks++;
        if (MdBusy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle5 got=%b exp=0", MdBusy);
        end
        MdStartD = 1; #1;
        checks++;
        if (StallF !== 1'b0) begin
            errors++; $display("FAIL b2b_nostall got=%b exp=0", StallF);
        end
        clear_inputs();
    endtask

    task automatic test_divide_reset();
        do_reset();
        MdStartE = 1; MdDivE = 1; #1;
        for (int c = 1; c <= 10; c++) begin
            step();
            MdStartE = 0;
        end
        MdReadD = 1; #1;
        checks++;
        if ({StallF, MdBusy} !== 2'b11) begin
            errors++; $display("FAIL div_busy got=%b exp=11", {StallF, MdBusy});
        end
        reset = 1;
        step();
        checks++;
        if ({StallF, MdBusy} !== 2'b00) begin
            errors++; $display("FAIL div_abort got=%b exp=00", {StallF, MdBusy});
        end
        checks++;
        if (StallCycles !== 32'd0) begin
            errors++; $display("FAIL div_count got=%0d exp=0", StallCycles);
        end
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_stall_counter();
        do_reset();
        MemtoRegE = 1; WriteRegE = 8; RsD = 8; #1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 15) begin
                checks++;
                if (s_StallCycles !== 32'h0000000F) begin
                    errors++; $display("FAIL sat_reach got=%h exp=0000000f", s_StallCycles);
                end
            end
        end
        checks++;
        if (s_StallCycles !== 32'h0000000F) begin
            errors++; $display("FAIL sat_hold got=%h exp=0000000f", s_StallCycles);
        end
        checks++;
        if (StallCycles !== 32'd20) begin
            errors++; $display("FAIL cnt_20 got=%0d exp=20", StallCycles);
        end
        clear_inputs();
        step();
        checks++;
        if (StallCycles !== 32'd20) begin
            errors++; $display("FAIL cnt_hold got=%0d exp=20", StallCycles);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_multiply();
        test_back_to_back();
        test_divide_reset();
        test_stall_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
